// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: 2-entry elastic stage with valid/ready on both sides.
// Holds up to two words (main + skid) so the upstream ready can be a pure
// register output, breaking the combinational ready chain between stages.
module pipe_skid_buffer #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             s_ready_q;
  logic             m_valid_q;
  logic [1:0]       count_q, count_d;

  logic in_xfer;
  logic out_xfer;

  // Handshakes use only registered ready/valid, so neither side sees a
  // combinational path through this block.
  assign in_xfer  = s_valid & s_ready_q;
  assign out_xfer = m_valid_q & m_ready;

  // Next-state and storage update; skid always holds the newer word.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = s_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        unique case ({in_xfer, out_xfer})
          2'b11: main_d = s_data;
          2'b10: begin
            skid_d  = s_data;
            state_d = FULL;
          end
          2'b01: state_d = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy of the next state, registered alongside it.
  always_comb begin
    count_d = 2'd0;
    unique case (state_d)
      BUSY:    count_d = 2'd1;
      FULL:    count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  // State, storage and registered flags; reset clears everything and holds
  // s_ready low until the first clock after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= (state_d != FULL);
      m_valid_q <= (state_d != EMPTY);
      count_q   <= count_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = main_q;
  assign count   = count_q;

endmodule

// File: doc/pipe_skid_buffer.md
Name: pipe_skid_buffer

Overview:
- Consumer-side companion to the team's plain DFF pipeline registers. A stage wrapped only in DFFs cannot accept backpressure; this block adds it.
- It is a 2-entry elastic pipeline stage with a valid/ready handshake on both sides.
- It accepts one word per cycle from an upstream DFF stage and holds it until the downstream reader accepts it.
- It sits between datapath pipeline stages wherever the downstream consumer can stall.

Parameters:
- WIDTH, 28, data word width in bits (instantiated at 28, 29, 14, 5, 4, 3 and 2 in the datapath).

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset. It is sampled only on the rising edge of clk and has priority over all other inputs.
- s_valid  input  1  upstream word present on s_data.
- s_ready  output  1  registered; block can accept a word this cycle.
- s_data  input  WIDTH  upstream word.
- m_valid  output  1  registered; m_data holds a valid word.
- m_ready  input  1  downstream accepts m_data this cycle.
- m_data  output  WIDTH  registered output word (main register).
- count  output  2  number of words held (0, 1 or 2).

Behaviour:
- Storage: main register (drives m_data) and skid register. Both are WIDTH bits.
- Transfers:
  - Input transfer (IN) = s_valid & s_ready.
  - Output transfer (OUT) = m_valid & m_ready.
  - Handshakes are evaluated on the same posedge.
- States, with count value in brackets:
  - EMPTY (0): m_valid=0, s_ready=1.
  - BUSY (1): m_valid=1, s_ready=1.
  - FULL (2): m_valid=1, s_ready=0.
- Transitions in EMPTY:
  - IN: main<=s_data, go to BUSY.
  - Otherwise stay. m_ready is ignored.
- Transitions in BUSY:
  - IN & OUT: main<=s_data, stay in BUSY (simultaneous read/write keeps one-per-cycle throughput).
  - IN & !OUT: skid<=s_data, go to FULL.
  - !IN & OUT: go to EMPTY. main is left unchanged (don't-care).
  - Neither: hold.
- Transitions in FULL:
  - OUT: main<=skid, go to BUSY.
  - Otherwise hold.
  - s_valid is ignored because s_ready=0; nothing is overwritten or dropped.
- Outputs:
  - s_ready = (next state != FULL), registered.
  - m_valid = (next state != EMPTY), registered.
  - count is registered and matches the state.
- Latency: a word accepted into EMPTY appears on m_data/m_valid the next cycle.
- Throughput: 1 word/cycle when m_ready is held high.
- Ordering: strict FIFO. The skid word is always newer than the main word.
- Stability: while m_valid=1 & m_ready=0, m_data and m_valid hold unchanged.
- s_ready depends only on registered state, never combinationally on m_ready. This cuts the ready path between stages.
- Reset (rst=1 at posedge), regardless of state or handshakes:
  - state<=EMPTY, main<=0, skid<=0, m_valid<=0, count<=0.
  - s_ready<=0; it rises to 1 at the first posedge with rst=0.
  - Any IN/OUT in a reset cycle is discarded.
  - Reset mid-operation discards held words with no partial output.
- m_data is not qualified: its value when m_valid=0 carries no meaning. Checkers must sample only on OUT.

Test Plan:
- Reset: hold rst=1 for 3 cycles with s_valid=1, s_data=28'h0ABCDEF -> m_valid=0, m_data=0, count=0, s_ready=0; after release, s_ready=1 one cycle later and no word emerges.
- Single pass: EMPTY, s_valid=1 for one cycle with data 28'h0000123, m_ready=1 -> m_valid=1, m_data=28'h0000123 the next cycle; EMPTY again after the OUT.
- Streaming: m_ready=1, 16 back-to-back words 0..15 -> 16 consecutive cycles of m_valid=1 with data 0..15 in order, s_ready never deasserts, count stays 1.
- Backpressure: m_ready=0, send 28'hA then 28'hB -> count=2, s_ready=0, m_data=28'hA held; s_valid held high with 28'hC is not accepted; raise m_ready -> outputs A, B, C in order.
- Simultaneous: BUSY holding 28'h5, IN=28'h6 and OUT in the same cycle -> stays BUSY, count=1, m_data=28'h6 the next cycle.
- Reset mid-operation: FULL holding 28'h1 and 28'h2, pulse rst=1 for one cycle -> count=0, m_valid=0, neither 28'h1 nor 28'h2 ever appears on an OUT.
